// File: rtl/matrix_grid_renderer.sv
// Renders a DIM x DIM matrix as a bordered colour grid on the VGA output.
// Elements arrive over a valid/ready write port into a double-buffered
// register file; the buffers swap only at vblank onset to avoid tearing.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   clk_en                pixel-rate enable (same strobe as the counters)
//   h_count, v_count      current raster position
//   hsync_in, vsync_in    sync from the counters
//   hblank_in, vblank_in  blanking from the counters
//   wr_valid/wr_ready     element write handshake
//   wr_addr, wr_data      element index (row*DIM+col) and value
//   wr_last               final element of a matrix; commits the back buffer
//   hsync, vsync          sync delayed to align with RGB
//   hblank, vblank        blanking delayed to align with RGB
//   vga_r, vga_g, vga_b   4-bit colour channels
module matrix_grid_renderer #(
   parameter int unsigned DIM       = 4,
   parameter int unsigned CELL_LOG2 = 6,
   parameter int unsigned BORDER    = 2,
   parameter int unsigned GRID_H0   = 304,
   parameter int unsigned GRID_V0   = 115,
   parameter logic [11:0] BG_RGB    = 12'h000,
   parameter logic        SYNC_IDLE = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clk_en,
   input  logic [10:0]                   h_count,
   input  logic [10:0]                   v_count,
   input  logic                          hsync_in,
   input  logic                          vsync_in,
   input  logic                          hblank_in,
   input  logic                          vblank_in,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [$clog2(DIM*DIM)-1:0]    wr_addr,
   input  logic [7:0]                    wr_data,
   input  logic                          wr_last,
   output logic                          hsync,
   output logic                          vsync,
   output logic                          hblank,
   output logic                          vblank,
   output logic [3:0]                    vga_r,
   output logic [3:0]                    vga_g,
   output logic [3:0]                    vga_b
);

   localparam int unsigned CELLS  = DIM * DIM;
   localparam int unsigned ADDR_W = $clog2(CELLS);
   localparam int unsigned RC_W   = $clog2(DIM + 1);
   localparam int unsigned SPAN   = (DIM << CELL_LOG2) + BORDER;

   // Two element banks; front_sel picks the displayed one.
   // wr_ready doubles as the inverse of the commit-pending flag.
   logic [7:0] mem [2][CELLS];
   logic       front_sel;

   // Stage-1 registers
   logic            s1_in_grid;
   logic            s1_border;
   logic [RC_W-1:0] s1_row;
   logic [RC_W-1:0] s1_col;
   logic            s1_hsync;
   logic            s1_vsync;
   logic            s1_hblank;
   logic            s1_vblank;

   // Stage-1 geometry: grid-relative offsets wrap for pixels left/above the grid
   logic [11:0]     dx_c;
   logic [11:0]     dy_c;
   logic            in_grid_c;
   logic [RC_W-1:0] col_c;
   logic [RC_W-1:0] row_c;
   logic            border_c;

   always_comb begin
      dx_c      = 12'(h_count) - 12'(GRID_H0);
      dy_c      = 12'(v_count) - 12'(GRID_V0);
      in_grid_c = (32'(dx_c) < SPAN) && (32'(dy_c) < SPAN);
      // Truncation is harmless: only used when in_grid, where col/row <= DIM
      col_c     = RC_W'(dx_c >> CELL_LOG2);
      row_c     = RC_W'(dy_c >> CELL_LOG2);
      border_c  = (32'(dx_c[CELL_LOG2-1:0]) < BORDER) ||
                  (32'(dy_c[CELL_LOG2-1:0]) < BORDER) ||
                  (32'(col_c) == DIM) || (32'(row_c) == DIM);
   end

   // Stage-2 colour lookup from the front bank
   logic [ADDR_W-1:0] idx_c;
   logic [7:0]        pix_c;
   logic [11:0]       rgb_c;

   always_comb begin
      // Out-of-range row/col only occur on the border, where the value is unused
      idx_c = ADDR_W'(32'(s1_row) * DIM + 32'(s1_col));
      pix_c = mem[front_sel][idx_c];
      rgb_c = 12'h000;
      if (s1_hblank || s1_vblank) begin
         rgb_c = 12'h000;
      end else if (!s1_in_grid) begin
         rgb_c = BG_RGB;
      end else if (s1_border) begin
         rgb_c = 12'hFFF;
      end else begin
         rgb_c = {pix_c[7:4], pix_c[3:0], 4'h0};
      end
   end

   // Pixel pipeline: two enabled stages, holds while clk_en is low
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_in_grid <= 1'b0;
         s1_border  <= 1'b0;
         s1_row     <= '0;
         s1_col     <= '0;
         s1_hsync   <= SYNC_IDLE;
         s1_vsync   <= SYNC_IDLE;
         s1_hblank  <= 1'b1;
         s1_vblank  <= 1'b1;
         hsync      <= SYNC_IDLE;
         vsync      <= SYNC_IDLE;
         hblank     <= 1'b1;
         vblank     <= 1'b1;
         vga_r      <= 4'h0;
         vga_g      <= 4'h0;
         vga_b      <= 4'h0;
      end else if (clk_en) begin
         s1_in_grid <= in_grid_c;
         s1_border  <= border_c;
         s1_row     <= row_c;
         s1_col     <= col_c;
         s1_hsync   <= hsync_in;
         s1_vsync   <= vsync_in;
         s1_hblank  <= hblank_in;
         s1_vblank  <= vblank_in;
         hsync      <= s1_hsync;
         vsync      <= s1_vsync;
         hblank     <= s1_hblank;
         vblank     <= s1_vblank;
         vga_r      <= rgb_c[11:8];
         vga_g      <= rgb_c[7:4];
         vga_b      <= rgb_c[3:0];
      end
   end

   // Vblank onset: stage-1 vblank holds the previous enabled-cycle value
   logic swap_c;
   logic addr_ok_c;

   always_comb begin
      swap_c    = clk_en && vblank_in && !s1_vblank && !wr_ready;
      addr_ok_c = 32'(wr_addr) < CELLS;
   end

   // Write port at full clock rate; swap toggles banks and reopens the port
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(CELLS); i++) begin
            mem[0][i] <= 8'h00;
            mem[1][i] <= 8'h00;
         end
         front_sel <= 1'b0;
         wr_ready  <= 1'b1;
      end else begin
         if (wr_valid && wr_ready) begin
            if (addr_ok_c) begin
               mem[~front_sel][wr_addr] <= wr_data;
            end
            if (wr_last) begin
               wr_ready <= 1'b0;
            end
         end
         if (swap_c) begin
            front_sel <= ~front_sel;
            wr_ready  <= 1'b1;
         end
      end
   end

endmodule
